msg_bank_ram: RTL and testbench

//  Banked single-port message memory for the LDPC decoder: LANES independent Q_WIDTH-bit LLR lanes

---
 rtl/msg_ram_pkg.sv | 25 ++
 rtl/msg_ram_lane.sv | 62 ++++++
 rtl/msg_bank_ram.sv | 108 ++++++++++
 tb/tb_msg_bank_ram.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/msg_ram_pkg.sv
// Shared types and constants for the banked LDPC message memory (msg_bank_ram).
// The optional parity bit per lane is enabled by defining MSG_RAM_PARITY_EN.
package msg_ram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

  localparam int DEF_LANES      = 3;
  localparam int DEF_Q_WIDTH    = 5;
  localparam int DEF_ADDR_WIDTH = 8;

`ifdef MSG_RAM_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Bit offset of lane 'lane' inside a packed multi-lane word.
  function automatic int lane_lsb(input int lane, input int q_width);
    return lane * q_width;
  endfunction

endpackage

// File: rtl/msg_ram_lane.sv
// One message lane: DEPTH x Q_WIDTH storage (plus an even-parity bit when
// MSG_RAM_PARITY_EN is defined), synchronous write and registered read.
module msg_ram_lane
  import msg_ram_pkg::*;
#(
  parameter int Q_WIDTH    = DEF_Q_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [Q_WIDTH-1:0]    wdata,
  output logic [Q_WIDTH-1:0]    rdata,
  output logic                  par_err
);

  localparam int SW = Q_WIDTH + PAR_BITS;

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] wr_word;
  logic [SW-1:0] rd_word;

`ifdef MSG_RAM_PARITY_EN
  assign wr_word = {^wdata, wdata};
`else
  assign wr_word = wdata;
`endif

  assign rd_word = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_word;
    end
  end

  // rdata holds between reads; out-of-range reads return zero without touching the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_zero ? '0 : rd_word[Q_WIDTH-1:0];
    end
  end

`ifdef MSG_RAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= rd_en && !rd_zero && (rd_word[Q_WIDTH] != ^rd_word[Q_WIDTH-1:0]);
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/msg_bank_ram.sv
// Banked single-port LLR message memory: LANES lanes sharing one address, per-lane write
// mask, registered read with rvalid, and a clear sequencer. Parity via MSG_RAM_PARITY_EN.
module msg_bank_ram
  import msg_ram_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int Q_WIDTH    = DEF_Q_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_req,
  output logic                       init_busy,
  input  logic                       cs,
  input  logic                       we,
  input  logic [LANES-1:0]           lane_we,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [LANES*Q_WIDTH-1:0]   wdata,
  output logic [LANES*Q_WIDTH-1:0]   rdata,
  output logic                       rvalid,
  output logic [LANES-1:0]           par_err,
  output state_t                     dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
  logic                    access;
  logic                    acc_wr;
  logic                    acc_rd;
  logic                    in_range;
  logic [ADDR_WIDTH-1:0]   mem_addr;

  // Access handshake: an access is accepted in any IDLE cycle where cs=1 and init_req=0;
  // there is no back-pressure, a read answers with rvalid exactly one cycle later, a write
  // gives no response. cs in INIT (or together with init_req) is dropped silently.
  assign access    = !rst && (state == IDLE) && cs && !init_req;
  assign in_range  = {1'b0, addr} < DEPTH_EXT;
  assign acc_wr    = access && we && in_range;
  assign acc_rd    = access && !we;
  assign init_busy = (state == INIT);
  assign mem_addr  = init_busy ? ptr : addr;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      ptr    <= '0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      rvalid <= acc_rd;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (init_req) begin
          state_next = INIT;
          ptr_next   = '0;
        end
      end
      INIT: begin
        ptr_next = ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = INIT;
        ptr_next   = '0;
      end
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int LSB = lane_lsb(l, Q_WIDTH);
    logic               lane_wr;
    logic [Q_WIDTH-1:0] lane_wdata;

    assign lane_wr    = init_busy || (acc_wr && lane_we[l]);
    assign lane_wdata = init_busy ? '0 : wdata[LSB +: Q_WIDTH];

    msg_ram_lane #(
      .Q_WIDTH   (Q_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (lane_wr),
      .rd_en  (acc_rd),
      .rd_zero(!in_range),
      .addr   (mem_addr),
      .wdata  (lane_wdata),
      .rdata  (rdata[LSB +: Q_WIDTH]),
      .par_err(par_err[l])
    );
  end

endmodule

// File: tb/tb_msg_bank_ram.sv
// Directed + randomized bench for msg_bank_ram: a full-depth instance and a DEPTH=200
// instance driven by the same stimulus, both checked against array models.
module tb_msg_bank_ram;
  import msg_ram_pkg::*;

  localparam int LANES = 3;
  localparam int QW    = 5;
  localparam int AW    = 8;
  localparam int W     = LANES * QW;
  localparam int D2    = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_req;
  logic             cs;
  logic             we;
  logic [LANES-1:0] lane_we;
  logic [AW-1:0]    addr;
  logic [W-1:0]     wdata;

  logic             init_busy,  init_busy2;
  logic [W-1:0]     rdata,      rdata2;
  logic             rvalid,     rvalid2;
  logic [LANES-1:0] par_err,    par_err2;
  state_t           dbg_state,  dbg_state2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mdl  [256];
  logic [W-1:0] mdl2 [256];
  logic [W-1:0] exp_q [$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  msg_bank_ram #(.LANES(LANES), .Q_WIDTH(QW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .init_busy(init_busy),
    .cs(cs), .we(we), .lane_we(lane_we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .par_err(par_err), .dbg_state(dbg_state)
  );

  msg_bank_ram #(.LANES(LANES), .Q_WIDTH(QW), .ADDR_WIDTH(AW), .DEPTH(D2)) dut2 (
    .clk(clk), .rst(rst), .init_req(init_req), .init_busy(init_busy2),
    .cs(cs), .we(we), .lane_we(lane_we), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .rvalid(rvalid2), .par_err(par_err2), .dbg_state(dbg_state2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      $error("check %s failed", tag);
    end
  endtask

  // Per-lane merge of new data into an old word under a lane mask.
  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [LANES-1:0] m);
    logic [W-1:0] r;
    r = old;
    for (int l = 0; l < LANES; l++) begin
      if (m[l]) r[l*QW +: QW] = d[l*QW +: QW];
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      mdl[i]  = '0;
      mdl2[i] = '0;
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [LANES-1:0] m);
    addr = a; wdata = d; lane_we = m; cs = 1'b1; we = 1'b1;
    cyc();
    cs = 1'b0; we = 1'b0;
    mdl[a] = merge(mdl[a], d, m);
    if (int'(a) < D2) mdl2[a] = merge(mdl2[a], d, m);
    check("wr_rvalid", {63'd0, rvalid}, 64'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic [W-1:0] e, e2;
    exp_q.push_back(mdl[a]);
    e2 = (int'(a) < D2) ? mdl2[a] : '0;
    addr = a; cs = 1'b1; we = 1'b0;
    cyc();
    cs = 1'b0;
    e = exp_q.pop_front();
    check("rd_rvalid",   {63'd0, rvalid},  64'd1);
    check("rd_data",     64'(rdata),       64'(e));
    check("rd_par",      64'(par_err),     64'd0);
    check("rd2_rvalid",  {63'd0, rvalid2}, 64'd1);
    check("rd2_data",    64'(rdata2),      64'(e2));
    check("rd2_par",     64'(par_err2),    64'd0);
  endtask

  initial begin
    int cnt, cnt2;
    logic [AW-1:0] a;

    rst = 1'b1; init_req = 1'b0; cs = 1'b0; we = 1'b0;
    lane_we = '0; addr = '0; wdata = '0;
    clear_models();

    // 1: reset, init length, reads of first and last entry
    cyc();
    rst = 1'b0;
    check("rst_busy",   {63'd0, init_busy}, 64'd1);
    check("rst_state",  64'(dbg_state),     64'(INIT));
    check("rst_rdata",  64'(rdata),         64'd0);
    check("rst_rvalid", {63'd0, rvalid},    64'd0);
    check("rst_par",    64'(par_err),       64'd0);
    cnt = 0; cnt2 = 0;
    while (init_busy && cnt < 1000) begin
      cnt++;
      if (init_busy2) cnt2++;
      cyc();
    end
    check("rst_busy_len",  64'(cnt),  64'd256);
    check("rst_busy_len2", 64'(cnt2), 64'd200);
    do_read(8'h00);
    do_read(8'hFF);
    cyc();
    check("rvalid_drop", {63'd0, rvalid}, 64'd0);

    // 2: masked write
    do_write(8'h10, 15'h7D43, 3'b101);
    do_read(8'h10);
    check("masked_const", 64'(rdata), 64'h7C03);

    // 3: read right after write, hold behaviour, out-of-range, random alternation
    do_write(8'h20, 15'h7FFF, 3'b111);
    do_read(8'h20);
    check("b2b_const", 64'(rdata), 64'h7FFF);
    cyc();
    check("hold_rvalid", {63'd0, rvalid}, 64'd0);
    check("hold_rdata",  64'(rdata),      64'h7FFF);
    do_write(8'hF0, 15'h7FFF, 3'b111);
    do_read(8'hF0);
    check("oor2_const", 64'(rdata2), 64'd0);
    do_write(8'h11, 15'h1234, 3'b000);
    do_read(8'h11);
    for (int i = 0; i < 100; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(190, 215));
      do_write(a, W'($urandom_range(0, 32767)), LANES'($urandom_range(0, 7)));
      do_read(a);
      if ($urandom_range(0, 3) == 0) do_read(8'($urandom_range(0, 255)));
    end

    // 4: fill, init with a colliding read, cs ignored during INIT, all entries cleared
    for (int i = 0; i < 256; i++) do_write(8'(i), 15'h5555, 3'b111);
    do_read(8'h80);
    addr = 8'h20; cs = 1'b1; we = 1'b0; init_req = 1'b1;
    cyc();
    cs = 1'b0; init_req = 1'b0;
    check("coll_rvalid", {63'd0, rvalid}, 64'd0);
    check("coll_busy",   {63'd0, init_busy}, 64'd1);
    cnt = 0; cnt2 = 0;
    while (init_busy && cnt < 1000) begin
      cnt++;
      if (init_busy2) cnt2++;
      cs      = (cnt <= 30);
      we      = ($urandom_range(0, 1) == 1);
      lane_we = 3'b111;
      addr    = 8'($urandom_range(0, 255));
      wdata   = W'($urandom_range(1, 32767));
      cyc();
      check("init_rvalid",  {63'd0, rvalid},  64'd0);
      check("init_rvalid2", {63'd0, rvalid2}, 64'd0);
    end
    cs = 1'b0; we = 1'b0;
    check("init_busy_len",  64'(cnt),  64'd256);
    check("init_busy_len2", 64'(cnt2), 64'd200);
    clear_models();
    for (int i = 0; i < 256; i++) do_read(8'(i));

    // 5: reset in the middle of INIT restarts the clear; init_req during INIT ignored
    do_write(8'h05, 15'h2AAA, 3'b111);
    init_req = 1'b1;
    cyc();
    init_req = 1'b0;
    repeat (100) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_rdata", 64'(rdata), 64'd0);
    cnt = 0; cnt2 = 0;
    while (init_busy && cnt < 1000) begin
      cnt++;
      if (init_busy2) cnt2++;
      init_req = (cnt == 50);
      cyc();
    end
    init_req = 1'b0;
    check("rst2_busy_len",  64'(cnt),  64'd256);
    check("rst2_busy_len2", 64'(cnt2), 64'd200);
    clear_models();
    do_read(8'h05);
    do_read(8'hF0);
    do_write(8'hF0, 15'h1234, 3'b111);
    do_read(8'hF0);
    check("oor2_after", 64'(rdata2), 64'd0);

`ifdef MSG_RAM_PARITY_EN
    // 6: corrupt one stored bit of lane 1 and expect a parity flag on that lane only
    do_write(8'h30, 15'h7FFF, 3'b111);
    dut.g_lane[1].u_lane.mem[8'h30][0] = ~dut.g_lane[1].u_lane.mem[8'h30][0];
    addr = 8'h30; cs = 1'b1; we = 1'b0;
    cyc();
    cs = 1'b0;
    check("par_rvalid", {63'd0, rvalid}, 64'd1);
    check("par_err",    64'(par_err),    64'b010);
    cyc();
    check("par_clear",  64'(par_err),    64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
